// File: rtl/regfile_bank.sv
// Parametrised register file: write decode, optional read bypass, shadow bank
// for exception save/restore, and a serial debug dump engine.
module regfile_bank #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int LINK_IDX  = 31,
  parameter int FLAG_IDX  = 30,
  parameter int BYPASS    = 1,
  parameter int SHADOW_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [1:0]        wr_dst,
  input  logic [2:0]        wr_src,
  input  logic [DATA_W-1:0] data_alu,
  input  logic [DATA_W-1:0] data_dm,
  input  logic [DATA_W-1:0] data_cp0,
  input  logic [DATA_W-1:0] data_prrd,
  input  logic [DATA_W-1:0] pc4,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] rs_out,
  output logic [DATA_W-1:0] rt_out,
  output logic              flag_out,
  input  logic              ctx_save,
  input  logic              ctx_restore,
  input  logic              dump_start,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done,
  output logic              dump_fsm_state
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_IDX);
  localparam logic [ADDR_W-1:0] FLAG_A = ADDR_W'(FLAG_IDX);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, DUMP} dump_state_t;

  logic [DATA_W-1:0] regs   [DEPTH];
  logic [DATA_W-1:0] shadow [DEPTH];
  logic              wr_ok;
  logic              wr_go;
  logic [ADDR_W-1:0] wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              save_en;
  logic              restore_en;
  dump_state_t       state;

  assign save_en    = (SHADOW_EN != 0) && ctx_save;
  assign restore_en = (SHADOW_EN != 0) && ctx_restore;

  always_comb begin
    wr_ok   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    case (wr_dst)
      2'b00, 2'b01: begin
        wr_idx = (wr_dst == 2'b00) ? rt : rd;
        wr_ok  = 1'b1;
        case (wr_src)
          3'b000:  wr_data = data_alu;
          3'b001:  wr_data = data_dm;
          3'b101:  wr_data = data_cp0;
          3'b110:  wr_data = data_prrd;
          default: wr_ok = 1'b0;
        endcase
      end
      2'b10: begin
        wr_idx  = LINK_A;
        wr_data = pc4;
        wr_ok   = 1'b1;
      end
      default: begin
        wr_idx  = FLAG_A;
        wr_data = DATA_W'(1);
        wr_ok   = (wr_src == 3'b011);
      end
    endcase
  end

  // Register 0 is hardwired, so a write aimed at it is dropped here once.
  assign wr_go = reg_write && wr_ok && (wr_idx != '0);

  always_comb begin
    rs_out = regs[rs];
    if (rs == '0) rs_out = '0;
    else if ((BYPASS != 0) && wr_go && (wr_idx == rs)) rs_out = wr_data;
    rt_out = regs[rt];
    if (rt == '0) rt_out = '0;
    else if ((BYPASS != 0) && wr_go && (wr_idx == rt)) rt_out = wr_data;
  end

  assign flag_out = (regs[FLAG_A] == DATA_W'(1));

  // Restore beats the same-edge write and the flag auto-clear; save samples
  // pre-edge contents, so save+restore together swaps the banks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (restore_en)
          regs[i] <= shadow[i];
        else if (wr_go && (wr_idx == ADDR_W'(i)))
          regs[i] <= wr_data;
        else if ((ADDR_W'(i) == FLAG_A) && (regs[i] == DATA_W'(1)))
          regs[i] <= '0;
        if (save_en)
          shadow[i] <= regs[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      dump_idx   <= '0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      dump_done  <= 1'b0;
    end else begin
      dump_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dump_start) begin
            state      <= DUMP;
            dump_idx   <= '0;
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
          end
        end
        default: begin
          if (dump_idx == LAST_A) begin
            state      <= IDLE;
            dump_idx   <= '0;
            dump_valid <= 1'b0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b1;
          end else begin
            dump_idx <= dump_idx + 1'b1;
          end
        end
      endcase
    end
  end

  // Stored contents only: a write landing this cycle shows up on a later index.
  assign dump_data      = dump_valid ? regs[dump_idx] : '0;
  assign dump_fsm_state = (state == DUMP);
endmodule

// File: tb/tb_regfile_bank.sv
// Directed bench for regfile_bank: one task per feature, inline checks, and a
// second instance with BYPASS=0 for the non-bypassed read path.
module tb_regfile_bank;
  logic        clk, reset, reg_write, ctx_save, ctx_restore, dump_start;
  logic [1:0]  wr_dst;
  logic [2:0]  wr_src;
  logic [31:0] data_alu, data_dm, data_cp0, data_prrd, pc4;
  logic [4:0]  rs, rt, rd;
  logic [31:0] rs_out, rt_out, dump_data;
  logic        flag_out, dump_valid, dump_busy, dump_done, dump_fsm_state;
  logic [4:0]  dump_idx;
  logic [31:0] nb_rs_out, nb_rt_out, nb_dump_data;
  logic        nb_flag_out, nb_dump_valid, nb_dump_busy, nb_dump_done, nb_dump_fsm_state;
  logic [4:0]  nb_dump_idx;
  int n_cmp = 0;
  int n_err = 0;

  regfile_bank #(.BYPASS(1)) dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .wr_dst(wr_dst), .wr_src(wr_src),
    .data_alu(data_alu), .data_dm(data_dm), .data_cp0(data_cp0), .data_prrd(data_prrd),
    .pc4(pc4), .rs(rs), .rt(rt), .rd(rd), .rs_out(rs_out), .rt_out(rt_out),
    .flag_out(flag_out), .ctx_save(ctx_save), .ctx_restore(ctx_restore),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_idx(dump_idx),
    .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done),
    .dump_fsm_state(dump_fsm_state));

  regfile_bank #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .reg_write(reg_write), .wr_dst(wr_dst), .wr_src(wr_src),
    .data_alu(data_alu), .data_dm(data_dm), .data_cp0(data_cp0), .data_prrd(data_prrd),
    .pc4(pc4), .rs(rs), .rt(rt), .rd(rd), .rs_out(nb_rs_out), .rt_out(nb_rt_out),
    .flag_out(nb_flag_out), .ctx_save(ctx_save), .ctx_restore(ctx_restore),
    .dump_start(dump_start), .dump_valid(nb_dump_valid), .dump_idx(nb_dump_idx),
    .dump_data(nb_dump_data), .dump_busy(nb_dump_busy), .dump_done(nb_dump_done),
    .dump_fsm_state(nb_dump_fsm_state));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One write cycle: inputs set at a falling edge, committed at the next rising edge.
  task automatic wr(input logic [1:0] dst, input logic [2:0] src, input logic [4:0] idx);
    @(negedge clk);
    reg_write = 1'b1; wr_dst = dst; wr_src = src; rt = idx; rd = idx;
    @(negedge clk);
    reg_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; reg_write = 0; wr_dst = 0; wr_src = 0; ctx_save = 0; ctx_restore = 0;
    dump_start = 0; data_alu = 0; data_dm = 0; data_cp0 = 0; data_prrd = 0; pc4 = 0;
    rs = 5'd5; rt = 5'd31; rd = 0;
    #2;
    n_cmp++; if (rs_out !== 32'h0) begin n_err++; $display("FAIL reset_rs: got %h want 0", rs_out); end
    n_cmp++; if (rt_out !== 32'h0) begin n_err++; $display("FAIL reset_rt: got %h want 0", rt_out); end
    n_cmp++; if (flag_out !== 1'b0) begin n_err++; $display("FAIL reset_flag: got %b want 0", flag_out); end
    n_cmp++; if ({dump_valid, dump_busy, dump_done, dump_fsm_state} !== 4'b0)
      begin n_err++; $display("FAIL reset_dump_ctl: got %b want 0000", {dump_valid, dump_busy, dump_done, dump_fsm_state}); end
    n_cmp++; if (dump_idx !== 5'd0) begin n_err++; $display("FAIL reset_dump_idx: got %0d want 0", dump_idx); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write();
    data_alu = 32'h1234;
    wr(2'b00, 3'b000, 5'd5);
    rs = 5'd5; #1;
    n_cmp++; if (rs_out !== 32'h0000_1234) begin n_err++; $display("FAIL write_r5: got %h want 00001234", rs_out); end
    data_alu = 32'hFFFF;
    wr(2'b00, 3'b000, 5'd0);
    rs = 5'd0; #1;
    n_cmp++; if (rs_out !== 32'h0) begin n_err++; $display("FAIL write_r0: got %h want 0", rs_out); end
    data_alu = 32'h1; data_dm = 32'h2; data_cp0 = 32'h3; data_prrd = 32'h4;
    wr(2'b01, 3'b001, 5'd8);
    wr(2'b01, 3'b101, 5'd9);
    wr(2'b00, 3'b110, 5'd10);
    wr(2'b00, 3'b011, 5'd11);
    wr(2'b01, 3'b111, 5'd12);
    rs = 5'd8; rt = 5'd9; #1;
    n_cmp++; if (rs_out !== 32'h2) begin n_err++; $display("FAIL src_dm: got %h want 2", rs_out); end
    n_cmp++; if (rt_out !== 32'h3) begin n_err++; $display("FAIL src_cp0: got %h want 3", rt_out); end
    rs = 5'd10; rt = 5'd11; #1;
    n_cmp++; if (rs_out !== 32'h4) begin n_err++; $display("FAIL src_prrd: got %h want 4", rs_out); end
    n_cmp++; if (rt_out !== 32'h0) begin n_err++; $display("FAIL src_011_nowrite: got %h want 0", rt_out); end
    rs = 5'd12; #1;
    n_cmp++; if (rs_out !== 32'h0) begin n_err++; $display("FAIL src_111_nowrite: got %h want 0", rs_out); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    data_dm = 32'hABCD; reg_write = 1'b1; wr_dst = 2'b01; wr_src = 3'b001; rd = 5'd7;
    rs = 5'd7; rt = 5'd7; #1;
    n_cmp++; if (rs_out !== 32'hABCD) begin n_err++; $display("FAIL bypass_rs: got %h want 0000abcd", rs_out); end
    n_cmp++; if (rt_out !== 32'hABCD) begin n_err++; $display("FAIL bypass_rt: got %h want 0000abcd", rt_out); end
    n_cmp++; if (nb_rs_out !== 32'h0) begin n_err++; $display("FAIL nobypass_rs: got %h want 0", nb_rs_out); end
    @(negedge clk);
    reg_write = 1'b0; #1;
    n_cmp++; if (nb_rs_out !== 32'hABCD) begin n_err++; $display("FAIL nobypass_after: got %h want 0000abcd", nb_rs_out); end
  endtask

  task automatic test_flag();
    wr(2'b11, 3'b011, 5'd0);
    #1;
    n_cmp++; if (flag_out !== 1'b1) begin n_err++; $display("FAIL flag_set: got %b want 1", flag_out); end
    @(negedge clk); #1;
    n_cmp++; if (flag_out !== 1'b0) begin n_err++; $display("FAIL flag_autoclear: got %b want 0", flag_out); end
    wr(2'b11, 3'b000, 5'd0);
    #1;
    n_cmp++; if (flag_out !== 1'b0) begin n_err++; $display("FAIL flag_badsrc: got %b want 0", flag_out); end
    pc4 = 32'h0040_0008;
    wr(2'b10, 3'b111, 5'd3);
    rs = 5'd31; rt = 5'd3; #1;
    n_cmp++; if (rs_out !== 32'h0040_0008) begin n_err++; $display("FAIL link_pc4: got %h want 00400008", rs_out); end
    n_cmp++; if (rt_out !== 32'h0) begin n_err++; $display("FAIL link_not_rt: got %h want 0", rt_out); end
  endtask

  task automatic test_shadow();
    data_alu = 32'h11;
    wr(2'b00, 3'b000, 5'd3);
    @(negedge clk); ctx_save = 1'b1;
    @(negedge clk); ctx_save = 1'b0;
    data_alu = 32'h22;
    wr(2'b00, 3'b000, 5'd3);
    rs = 5'd3; #1;
    n_cmp++; if (rs_out !== 32'h22) begin n_err++; $display("FAIL shadow_write22: got %h want 22", rs_out); end
    @(negedge clk);
    data_alu = 32'h33; reg_write = 1'b1; wr_dst = 2'b00; wr_src = 3'b000; rt = 5'd3; ctx_restore = 1'b1;
    @(negedge clk);
    reg_write = 1'b0; ctx_restore = 1'b0; rs = 5'd3; #1;
    n_cmp++; if (rs_out !== 32'h11) begin n_err++; $display("FAIL restore_wins: got %h want 11", rs_out); end
    data_alu = 32'h55;
    wr(2'b00, 3'b000, 5'd3);
    @(negedge clk); ctx_save = 1'b1; ctx_restore = 1'b1;
    @(negedge clk); ctx_save = 1'b0; ctx_restore = 1'b0; #1;
    n_cmp++; if (rs_out !== 32'h11) begin n_err++; $display("FAIL swap_main: got %h want 11", rs_out); end
    @(negedge clk); ctx_restore = 1'b1;
    @(negedge clk); ctx_restore = 1'b0; #1;
    n_cmp++; if (rs_out !== 32'h55) begin n_err++; $display("FAIL swap_shadow: got %h want 55", rs_out); end
    @(negedge clk);
    data_alu = 32'h66; reg_write = 1'b1; wr_dst = 2'b00; wr_src = 3'b000; rt = 5'd3; ctx_save = 1'b1;
    @(negedge clk);
    reg_write = 1'b0; ctx_save = 1'b0; #1;
    n_cmp++; if (rs_out !== 32'h66) begin n_err++; $display("FAIL save_with_write: got %h want 66", rs_out); end
    @(negedge clk); ctx_restore = 1'b1;
    @(negedge clk); ctx_restore = 1'b0; #1;
    n_cmp++; if (rs_out !== 32'h55) begin n_err++; $display("FAIL save_precontent: got %h want 55", rs_out); end
  endtask

  task automatic test_dump();
    logic [31:0] exp_data;
    for (int i = 1; i < 32; i++) begin
      data_alu = 32'(i);
      wr(2'b00, 3'b000, 5'(i));
    end
    @(negedge clk); dump_start = 1'b1;
    @(negedge clk); dump_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      exp_data = (i == 25) ? 32'hBEEF : 32'(i);
      n_cmp++; if ({dump_valid, dump_busy, dump_done} !== 3'b110 || dump_idx !== 5'(i) || dump_data !== exp_data) begin
        n_err++;
        $display("FAIL dump_beat%0d: got v%b b%b d%b idx %0d data %h want v1 b1 d0 idx %0d data %h",
                 i, dump_valid, dump_busy, dump_done, dump_idx, dump_data, i, exp_data);
      end
      dump_start = (i == 5);
      reg_write = (i == 20); wr_dst = 2'b00; wr_src = 3'b000; rt = 5'd25; data_alu = 32'hBEEF;
      @(negedge clk);
    end
    reg_write = 1'b0; dump_start = 1'b0; #1;
    n_cmp++; if ({dump_valid, dump_busy, dump_done} !== 3'b001)
      begin n_err++; $display("FAIL dump_done: got v%b b%b d%b want v0 b0 d1", dump_valid, dump_busy, dump_done); end
    @(negedge clk); #1;
    n_cmp++; if ({dump_valid, dump_busy, dump_done} !== 3'b000)
      begin n_err++; $display("FAIL dump_done_pulse: got v%b b%b d%b want 000", dump_valid, dump_busy, dump_done); end
  endtask

  task automatic test_reset_mid_dump();
    bit hit = 0;
    @(negedge clk); dump_start = 1'b1;
    @(negedge clk); dump_start = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      if (dump_idx == 5'd10) hit = 1;
      else @(negedge clk);
    end
    n_cmp++; if (!hit) begin n_err++; $display("FAIL mid_dump_reach10: got idx %0d want 10", dump_idx); end
    reset = 1'b1; rs = 5'd5; rt = 5'd31; #1;
    n_cmp++; if ({dump_valid, dump_busy, dump_done} !== 3'b000 || dump_idx !== 5'd0 || dump_data !== 32'h0)
      begin n_err++; $display("FAIL mid_dump_reset: got v%b b%b d%b idx %0d data %h want all 0", dump_valid, dump_busy, dump_done, dump_idx, dump_data); end
    n_cmp++; if (rs_out !== 32'h0 || rt_out !== 32'h0)
      begin n_err++; $display("FAIL mid_dump_regs: got %h %h want 0 0", rs_out, rt_out); end
    @(negedge clk); reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_bypass();
    test_flag();
    test_shadow();
    test_dump();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_bank.md
Name: regfile_bank

Overview:
Parametrised general-purpose register file for the multicycle CPU and the successor to the current fixed 32x32 file. It supports generic width and depth and keeps the write-destination and write-source decode. It adds:
- optional write-to-read bypass,
- a shadow bank for exception save/restore,
- a serial debug dump engine that streams every register out, one per cycle.

It sits between the control unit/datapath muxes and the ALU operand registers.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; DEPTH = 2**ADDR_W
LINK_IDX, 31, register written with pc4 when wr_dst=10
FLAG_IDX, 30, self-clearing flag register (wr_dst=11)
BYPASS, 1, 1 = a read of the register being written this cycle returns the write data
SHADOW_EN, 1, 1 = shadow bank and save/restore present; 0 = save/restore ignored

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
reg_write  in  1  write enable
wr_dst  in  2  00 rt, 01 rd, 10 LINK_IDX, 11 FLAG_IDX
wr_src  in  3  000 data_alu, 001 data_dm, 101 data_cp0, 110 data_prrd, 011 flag-set; others no write
data_alu, data_dm, data_cp0, data_prrd, pc4  in  DATA_W each  write data candidates
rs, rt, rd  in  ADDR_W  register indices
rs_out, rt_out  out  DATA_W  combinational read data
flag_out  out  1  (reg[FLAG_IDX] == 1)
ctx_save  in  1  copy main bank to shadow
ctx_restore  in  1  copy shadow to main bank
dump_start  in  1  start a debug dump
dump_valid  out  1  dump_data/dump_idx valid
dump_idx  out  ADDR_W  index being dumped
dump_data  out  DATA_W  contents of reg[dump_idx]
dump_busy  out  1  dump engine active
dump_done  out  1  one-cycle pulse after the last register

Behaviour:
- Reset (async): all main and shadow registers 0; dump FSM to IDLE. dump_valid, dump_busy, dump_done, dump_idx and flag_out are all 0.
- Write target and data decode:
  - dst 00 or 01: target rt or rd; data selected by wr_src (both destinations accept all four sources). Index 0 is never written.
  - dst 10: target LINK_IDX, data pc4; wr_src is ignored.
  - dst 11: target FLAG_IDX, data 1. Written only when wr_src = 011; otherwise no write.
  - Unlisted wr_src codes for dst 00/01: no write.
- Register 0 always reads 0.
- Flag auto-clear: if reg[FLAG_IDX] == 1 at a clock edge and no write targets FLAG_IDX that edge, it becomes 0. A same-edge write wins. The flag is therefore high for exactly one cycle per set unless it is re-set.
- Reads are combinational.
  - BYPASS=1: when reg_write is high and the decoded target equals the read index (nonzero), the output is the decoded write data.
  - BYPASS=0: reads return stored contents.
- Save/restore (SHADOW_EN=1), evaluated at the rising edge:
  - save: shadow <= main pre-edge contents. A same-edge write is not captured.
  - restore: main <= shadow. This overrides the same-edge write and the flag auto-clear.
  - save and restore together: banks swap.
- Dump FSM, states IDLE and DUMP:
  - IDLE, dump_start=1: go to DUMP with dump_idx = 0.
  - In DUMP, every cycle: dump_valid = 1, dump_busy = 1, dump_data = stored reg[dump_idx] (no bypass); dump_idx increments.
  - When dump_idx = DEPTH-1: next state IDLE, dump_done = 1 for one cycle, dump_idx returns to 0.
  - dump_start is ignored while in DUMP.
  - Writes and restore proceed during a dump; later indices show updated contents.
  - Reset mid-dump: immediately IDLE, all dump outputs 0.
- Total dump length is DEPTH cycles of dump_valid. dump_done is asserted on the cycle after the last valid cycle.

Test Plan:
1. Reset, then write 0x1234 to rt=5 via dst 00 / src 000 -> next cycle rs=5 reads 0x00001234. Write 0xFFFF to rt=0 -> reg0 still reads 0.
2. BYPASS=1: reg_write, dst 01, rd=7, src 001, data_dm=0xABCD, rs=7 in the same cycle -> rs_out=0xABCD combinationally. BYPASS=0 -> rs_out shows the old value.
3. dst 11, src 011 for one cycle -> flag_out=1 for exactly one cycle, then 0. dst 10 with pc4=0x0040_0008 -> reg31 = 0x0040_0008.
4. Set reg3=0x11 then save; write reg3=0x22; restore together with a write of reg3=0x33 -> reg3 = 0x11. Assert save and restore together -> banks swap.
5. Load reg i = i, pulse dump_start -> dump_valid for 32 cycles with dump_idx/dump_data 0..31 matching, then dump_done for one cycle. A dump_start mid-dump has no effect.
6. Assert reset at dump_idx = 10 -> dump_valid, dump_busy and all registers are 0 immediately, without waiting for a clock edge.
